// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step controller turning the divided clock or a debounced button into a one-cycle CPU enable
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        mode_run,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic [15:0] step_count,
  output logic [1:0]  state,
  output logic        btn_stable
);
  typedef enum logic [1:0] {HALT, RUN, STEP, HOLD} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q, state_d;
  logic [2:0] tick_q;
  logic [1:0] mode_q, btn_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] step_count_q, step_count_d;
  logic btn_stable_q, btn_stable_d, btn_prev_q, cpu_en_q, cpu_en_d;
  logic mode_run_s, step_btn_s, tick_rise, press, cnt_done;
  always_comb begin
    mode_run_s = mode_q[1];
    step_btn_s = btn_q[1];
    tick_rise = tick_q[1] & ~tick_q[2];
    press = btn_stable_q & ~btn_prev_q;
    cnt_done = cnt_q == CNT_MAX;
    cnt_d = (step_btn_s == btn_stable_q || cnt_done) ? '0 : cnt_q + 1'b1;
    btn_stable_d = (step_btn_s != btn_stable_q && cnt_done) ? step_btn_s : btn_stable_q;
    cpu_en_d = ~halt & ((state_q == RUN && mode_run_s && tick_rise) || (state_q == STEP && !mode_run_s && press));
    state_d = halt ? HALT :
              (state_q == HALT || state_q == RUN) ? (mode_run_s ? RUN : STEP) :
              mode_run_s ? RUN :
              (state_q == STEP) ? (press ? HOLD : STEP) :
              (btn_stable_q ? HOLD : STEP);
    step_count_d = step_count_q + 16'(cpu_en_d);
  end
  // tick_q: [0] metastable, [1] synchronized, [2] previous synchronized
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      mode_q <= '0;
      btn_q <= '0;
      cnt_q <= '0;
      btn_stable_q <= 1'b0;
      btn_prev_q <= 1'b0;
      cpu_en_q <= 1'b0;
      step_count_q <= '0;
      state_q <= HALT;
    end else begin
      tick_q <= {tick_q[1:0], tick_in};
      mode_q <= {mode_q[0], mode_run};
      btn_q <= {btn_q[0], step_btn};
      cnt_q <= cnt_d;
      btn_stable_q <= btn_stable_d;
      btn_prev_q <= btn_stable_q;
      cpu_en_q <= cpu_en_d;
      step_count_q <= step_count_d;
      state_q <= state_d;
    end
  end
  assign cpu_en = cpu_en_q;
  assign step_count = step_count_q;
  assign state = state_q;
  assign btn_stable = btn_stable_q;
endmodule
